// File: rtl/flags_stack_if.sv
// Flag register bus: ALU update strobes in, flag vector and stack status out.
interface flags_stack_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             en;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] mask;
    logic             sticky;
    logic             clr;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] flags;
    logic             overflow;
    logic             carry;
    logic             negative;
    logic             zero;
    logic [LW-1:0]    level;
    logic             full;
    logic             empty;
    logic             err;
    logic             changed;

    modport master (
        output en, upd, mask, sticky, clr, push, pop,
        input  flags, overflow, carry, negative, zero,
        input  level, full, empty, err, changed
    );

    modport slave (
        input  en, upd, mask, sticky, clr, push, pop,
        output flags, overflow, carry, negative, zero,
        output level, full, empty, err, changed
    );
endinterface

// File: rtl/flags_stack.sv
// Status-flag register with masked overwrite/sticky update and a LIFO save stack.
// Optional FLAGS_CHANGE_DETECT_EN builds the registered CHANGED pulse.
module flags_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    flags_stack_if.slave bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] flags_q, flags_d;
    logic [LW-1:0]    level_q, level_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic             push_we;
    logic             full, empty;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic [LW-1:0]    top_l;
    logic [WIDTH-1:0] upd_m;

    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    assign top_l  = level_q - LW'(1);
    assign wr_idx = level_q[IW-1:0];
    assign rd_idx = top_l[IW-1:0];
    assign upd_m  = bus.upd & bus.mask;

    // CLR beats POP, POP beats PUSH/EN; PUSH saves the pre-update value
    always_comb begin
        flags_d = flags_q;
        level_d = level_q;
        err_d   = err_q;
        push_we = 1'b0;
        if (bus.clr) begin
            flags_d = '0;
            err_d   = 1'b0;
        end else if (bus.pop) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                flags_d = stack_q[rd_idx];
                level_d = top_l;
            end
        end else begin
            if (bus.push) begin
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    push_we = 1'b1;
                    level_d = level_q + LW'(1);
                end
            end
            if (bus.en) begin
                if (bus.sticky) begin
                    flags_d = flags_q | upd_m;
                end else begin
                    flags_d = (flags_q & ~bus.mask) | upd_m;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            flags_q <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset here
    always_ff @(posedge clk_i) begin
        if (rst_ni && push_we) begin
            stack_q[wr_idx] <= flags_q;
        end
    end

`ifdef FLAGS_CHANGE_DETECT_EN
    logic changed_q, changed_d;

    assign changed_d = (flags_d != flags_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign bus.changed = changed_q;
`else
    assign bus.changed = 1'b0;
`endif

    assign bus.flags    = flags_q;
    assign bus.overflow = flags_q[0];
    assign bus.carry    = flags_q[1];
    assign bus.negative = flags_q[2];
    assign bus.zero     = flags_q[3];
    assign bus.level    = level_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_flags_stack.sv
// Scoreboarded random + directed bench for flags_stack.
// Queue-based reference model; monitor compares every cycle at negedge.
module tb_flags_stack;
    localparam int W = 4;
    localparam int D = 4;
    localparam int LW = $clog2(D + 1);

    typedef struct {
        logic [W-1:0] flags;
        int           level;
        logic         err;
        logic         changed;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    flags_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

    flags_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         exp_q[$];
    logic [W-1:0] m_flags;
    logic [W-1:0] m_stack[$];
    logic         m_err;
    logic         m_chg;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    // Behavioural model: priority rules applied with plain queue ops
    task automatic model_edge();
        logic [W-1:0] old;
        exp_t e;
        old = m_flags;
        if (!rst_n) begin
            m_flags = '0;
            m_stack.delete();
            m_err = 1'b0;
            m_chg = 1'b0;
        end else begin
            if (bus.clr) begin
                m_flags = '0;
                m_err = 1'b0;
            end else if (bus.pop) begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else m_flags = m_stack.pop_back();
            end else begin
                if (bus.push) begin
                    if (m_stack.size() == D) m_err = 1'b1;
                    else m_stack.push_back(m_flags);
                end
                if (bus.en) begin
                    for (int b = 0; b < W; b++) begin
                        if (bus.mask[b]) begin
                            if (bus.sticky) m_flags[b] = m_flags[b] | bus.upd[b];
                            else m_flags[b] = bus.upd[b];
                        end
                    end
                end
            end
`ifdef FLAGS_CHANGE_DETECT_EN
            m_chg = (m_flags != old);
`else
            m_chg = 1'b0;
`endif
        end
        e.flags = m_flags;
        e.level = m_stack.size();
        e.err = m_err;
        e.changed = m_chg;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("flags", 32'(bus.flags), 32'(e.flags));
            chk("ovf", 32'(bus.overflow), 32'(e.flags[0]));
            chk("carry", 32'(bus.carry), 32'(e.flags[1]));
            chk("neg", 32'(bus.negative), 32'(e.flags[2]));
            chk("zero", 32'(bus.zero), 32'(e.flags[3]));
            chk("level", 32'(bus.level), 32'(e.level));
            chk("full", 32'(bus.full), 32'(e.level == D));
            chk("empty", 32'(bus.empty), 32'(e.level == 0));
            chk("err", 32'(bus.err), 32'(e.err));
            chk("changed", 32'(bus.changed), 32'(e.changed));
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [W-1:0] u,
                       input logic [W-1:0] m, input logic s, input logic c,
                       input logic pu, input logic po);
        rst_n = r;
        bus.en = e;
        bus.upd = u;
        bus.mask = m;
        bus.sticky = s;
        bus.clr = c;
        bus.push = pu;
        bus.pop = po;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wr(input logic [W-1:0] u, input logic pu);
        cyc(1, 1, u, 4'hF, 0, 0, pu, 0);
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, required completion");
        finish_run();
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        m_flags = '0;
        m_err = 1'b0;
        m_chg = 1'b0;
        rst_n = 1'b0;
        bus.en = 0; bus.upd = '0; bus.mask = '0; bus.sticky = 0;
        bus.clr = 0; bus.push = 0; bus.pop = 0;

        cyc(0, 1, 4'hF, 4'hF, 0, 0, 0, 0);
        chk("rst_flags", 32'(bus.flags), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        cyc(1, 1, 4'b1010, 4'hF, 0, 0, 0, 0);
        chk("ovw_flags", 32'(bus.flags), 32'hA);
        cyc(1, 1, 4'b0101, 4'b0011, 0, 0, 0, 0);
        chk("mask_flags", 32'(bus.flags), 32'h9);

        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 4'b0001, 4'hF, 1, 0, 0, 0);
        cyc(1, 1, 4'b0100, 4'hF, 1, 0, 0, 0);
        cyc(1, 1, 4'b0000, 4'hF, 1, 0, 0, 0);
        chk("sticky_flags", 32'(bus.flags), 32'h5);

        wr(4'h1, 0);
        wr(4'h2, 1);
        wr(4'h3, 1);
        wr(4'h4, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        chk("full", 32'(bus.full), 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        chk("push_full_err", 32'(bus.err), 1);
        chk("push_full_lvl", 32'(bus.level), 4);
        for (int i = 4; i >= 1; i--) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 1);
            chk("pop_order", 32'(bus.flags), 32'(i));
        end
        chk("pop_empty", 32'(bus.empty), 1);
        cyc(1, 0, 0, 0, 0, 1, 0, 0);

        wr(4'h6, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        chk("pope_flags", 32'(bus.flags), 32'h6);
        chk("pope_err", 32'(bus.err), 1);
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        chk("clr_err", 32'(bus.err), 0);

        wr(4'h2, 0);
        wr(4'h9, 1);
        chk("sim_push", 32'(bus.flags), 32'h9);
        cyc(1, 1, 4'hF, 4'hF, 0, 0, 0, 1);
        chk("sim_pop", 32'(bus.flags), 32'h2);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 1);
        chk("clrpop_lvl", 32'(bus.level), 1);

        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        chk("mid_lvl", 32'(bus.level), 3);
        cyc(0, 1, 4'hF, 4'hF, 0, 0, 1, 0);
        chk("mid_rst_lvl", 32'(bus.level), 0);
        chk("mid_rst_err", 32'(bus.err), 0);
        wr(4'h8, 0);
`ifdef FLAGS_CHANGE_DETECT_EN
        chk("chg_pulse", 32'(bus.changed), 1);
`endif
        wr(4'h8, 0);
        chk("chg_same", 32'(bus.changed), 0);

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(49) != 0), ($urandom_range(1) == 1),
                W'($urandom), W'($urandom), ($urandom_range(1) == 1),
                ($urandom_range(14) == 0), ($urandom_range(2) == 0),
                ($urandom_range(3) == 0));
        end

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 0);
        finish_run();
    end
endmodule
